// File: rtl/vx_kernel_launcher.sv
// Launch sequencer for Vortex_axi: holds the GPU in reset, programs the startup DCRs,
// releases the GPU, then waits for busy to rise and fall (or a run limit) and reports the run length.
module vx_kernel_launcher #(
  parameter int DCR_ADDR_WIDTH = 12,
  parameter int DCR_DATA_WIDTH = 32,
  parameter int RST_CYCLES     = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [63:0]               startup_addr,
  input  logic [63:0]               startup_arg,
  input  logic [CNT_WIDTH-1:0]      timeout_cycles,
  output logic                      ready,
  output logic                      gpu_reset,
  output logic                      dcr_wr_valid,
  output logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
  output logic [DCR_DATA_WIDTH-1:0] dcr_wr_data,
  input  logic                      busy,
  output logic                      done,
  output logic                      timed_out,
  output logic [CNT_WIDTH-1:0]      cycle_count,
  output logic [2:0]                fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_WR      = 3'd2,
    S_GAP     = 3'd3,
    S_WAIT_HI = 3'd4,
    S_WAIT_LO = 3'd5
  } state_t;

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t                state_q, state_d;
  logic [HW-1:0]         hold_cnt;
  logic [2:0]            wr_idx;
  logic [63:0]           addr_q, arg_q;
  logic [CNT_WIDTH-1:0]  timeout_q, count_q;
  logic                  done_q, to_q;
  logic                  accept, waiting, limit_hit, fin_done, fin_to;
  logic [31:0]           wr_word;

  // ready stays low through the pulse cycle so a new launch cannot overlap the report
  assign ready     = (state_q == S_IDLE) && !done_q && !to_q;
  assign accept    = ready && start;
  assign waiting   = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
  assign limit_hit = (timeout_q != '0) && (count_q == timeout_q);
  assign fin_done  = (state_q == S_WAIT_LO) && !busy;
  assign fin_to    = waiting && limit_hit && !fin_done;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_HOLD;
      S_HOLD:    if (hold_cnt == HW'(RST_CYCLES - 1)) state_d = S_WR;
      S_WR:      state_d = S_GAP;
      S_GAP:     state_d = (wr_idx == 3'd4) ? S_WAIT_HI : S_WR;
      S_WAIT_HI: if (fin_to) state_d = S_IDLE;
                 else if (busy) state_d = S_WAIT_LO;
      S_WAIT_LO: if (fin_done || fin_to) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_cnt  <= '0;
      wr_idx    <= '0;
      addr_q    <= '0;
      arg_q     <= '0;
      timeout_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      done_q <= fin_done;
      to_q   <= fin_to;
      if (accept) begin
        addr_q    <= startup_addr;
        arg_q     <= startup_arg;
        timeout_q <= timeout_cycles;
        count_q   <= '0;
        hold_cnt  <= '0;
        wr_idx    <= '0;
      end
      if (state_q == S_HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (state_q == S_GAP && wr_idx != 3'd4) wr_idx <= wr_idx + 3'd1;
      // the terminating edge does not count, so the result reads as the run length
      if (waiting && !fin_done && !fin_to && count_q != '1) count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    wr_word = 32'h0;
    case (wr_idx)
      3'd0:    wr_word = addr_q[31:0];
      3'd1:    wr_word = addr_q[63:32];
      3'd2:    wr_word = arg_q[31:0];
      3'd3:    wr_word = arg_q[63:32];
      default: wr_word = 32'h0;
    endcase
  end

  assign gpu_reset    = !waiting;
  assign dcr_wr_valid = (state_q == S_WR);
  assign dcr_wr_addr  = (state_q == S_WR || state_q == S_GAP)
                        ? DCR_ADDR_WIDTH'(wr_idx) + DCR_ADDR_WIDTH'(1) : '0;
  assign dcr_wr_data  = (state_q == S_WR || state_q == S_GAP) ? DCR_DATA_WIDTH'(wr_word) : '0;
  assign done         = done_q;
  assign timed_out    = to_q;
  assign cycle_count  = count_q;
  assign fsm_state    = state_q;

endmodule
